// File: rtl/dsp_unpack_v4.sv
// dsp_unpack_v4: serialises the selected 12-bit lanes of a packed 48-bit DSP word, one lane per beat.
// Define DSP_UNPACK_OVF_EN to add the out_ovf port, flagging lane bits lost above `width`.
module dsp_unpack_v4 #(
    parameter int width = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      in_data,
    input  logic [3:0]       in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic [1:0]       out_lane,
    output logic             out_last,
`ifdef DSP_UNPACK_OVF_EN
    output logic             out_ovf,
`endif
    output logic [15:0]      word_count
);

    if (width < 1 || width > 12) begin : g_bad_width
        $error("dsp_unpack_v4: width must be in 1..12");
    end

    logic [47:0] buf_q,   buf_d;
    logic [3:0]  pend_q,  pend_d;
    logic [15:0] count_q, count_d;

    logic [1:0]  lane_idx;
    logic [3:0]  lane_bit;
    logic [11:0] lane_full;
    logic        pend_any;
    logic        pend_one;
    logic        beat;
    logic        last_beat;
    logic        accept;
    logic        zero_accept;

    // Lowest pending lane is emitted first.
    always_comb begin
        lane_idx = 2'd0;
        casez (pend_q)
            4'b???1: lane_idx = 2'd0;
            4'b??10: lane_idx = 2'd1;
            4'b?100: lane_idx = 2'd2;
            default: lane_idx = 2'd3;
        endcase
    end

    always_comb begin
        lane_full = buf_q[11:0];
        case (lane_idx)
            2'd0:    lane_full = buf_q[11:0];
            2'd1:    lane_full = buf_q[23:12];
            2'd2:    lane_full = buf_q[35:24];
            default: lane_full = buf_q[47:36];
        endcase
    end

    assign lane_bit    = 4'b0001 << lane_idx;
    assign pend_any    = |pend_q;
    assign pend_one    = pend_any && ((pend_q & (pend_q - 4'd1)) == '0);
    assign beat        = pend_any && out_ready;
    assign last_beat   = beat && pend_one;
    assign in_ready    = !pend_any || last_beat;
    assign accept      = in_valid && in_ready;
    assign zero_accept = accept && (in_mask == '0);

    assign out_valid   = pend_any;
    assign out_lane    = pend_any ? lane_idx : 2'd0;
    assign out_last    = pend_one;
    assign out_data    = pend_any ? lane_full[width-1:0] : '0;
    assign word_count  = count_q;

`ifdef DSP_UNPACK_OVF_EN
    // Shifting by width leaves only the spilled bits; zero when width is 12.
    assign out_ovf = pend_any && (|(lane_full >> width));
`endif

    // A new word's mask overrides the clearing of the retiring word's last bit.
    always_comb begin
        buf_d   = buf_q;
        pend_d  = pend_q;
        count_d = count_q + {15'd0, last_beat} + {15'd0, zero_accept};
        if (beat) begin
            pend_d = pend_q & ~lane_bit;
        end
        if (accept) begin
            buf_d  = in_data;
            pend_d = in_mask;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_q   <= '0;
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_dsp_unpack_v4.sv
// tb_dsp_unpack_v4: directed and randomized check of dsp_unpack_v4 at width 12 and width 8
// against a queue-based model of the lane serialiser.
module tb_dsp_unpack_v4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [47:0] in_data;
    logic [3:0]  in_mask;

    logic        rdy12, rdy8, v12, v8, l12, l8;
    logic [11:0] d12;
    logic [7:0]  d8;
    logic [1:0]  ln12, ln8;
    logic [15:0] wc12, wc8;
`ifdef DSP_UNPACK_OVF_EN
    logic        ovf12, ovf8;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    dsp_unpack_v4 #(.width(12)) u_dut12 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(rdy12), .in_data(in_data), .in_mask(in_mask),
        .out_valid(v12), .out_ready(out_ready), .out_data(d12), .out_lane(ln12),
        .out_last(l12),
`ifdef DSP_UNPACK_OVF_EN
        .out_ovf(ovf12),
`endif
        .word_count(wc12)
    );

    dsp_unpack_v4 #(.width(8)) u_dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data), .in_mask(in_mask),
        .out_valid(v8), .out_ready(out_ready), .out_data(d8), .out_lane(ln8),
        .out_last(l8),
`ifdef DSP_UNPACK_OVF_EN
        .out_ovf(ovf8),
`endif
        .word_count(wc8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Model: the latched word plus a queue of lane indices still to be emitted.
    logic [47:0] m_word = '0;
    int          m_q[$];
    logic [15:0] m_wc = '0;

    always @(negedge clock) begin
        bit          ev, el, er;
        int          lane;
        logic [11:0] full;
        ev   = (m_q.size() != 0);
        lane = ev ? m_q[0] : 0;
        full = ev ? 12'(m_word >> (12 * lane)) : 12'd0;
        el   = (m_q.size() == 1);
        er   = !ev || (out_ready && el);

        chk("m_valid12", 64'(v12),  64'(ev));
        chk("m_valid8",  64'(v8),   64'(ev));
        chk("m_lane12",  64'(ln12), 64'(lane));
        chk("m_lane8",   64'(ln8),  64'(lane));
        chk("m_data12",  64'(d12),  64'(full));
        chk("m_data8",   64'(d8),   64'(full[7:0]));
        chk("m_last12",  64'(l12),  64'(el));
        chk("m_last8",   64'(l8),   64'(el));
        chk("m_rdy12",   64'(rdy12), 64'(er));
        chk("m_rdy8",    64'(rdy8),  64'(er));
        chk("m_wc12",    64'(wc12), 64'(m_wc));
        chk("m_wc8",     64'(wc8),  64'(m_wc));
`ifdef DSP_UNPACK_OVF_EN
        chk("m_ovf12",   64'(ovf12), 64'd0);
        chk("m_ovf8",    64'(ovf8),  64'(ev && (full[11:8] != 4'd0)));
`endif

        // Advance to the state after the coming rising edge (inputs are stable until then).
        if (reset) begin
            m_q.delete();
            m_word = '0;
            m_wc   = '0;
        end else begin
            if (ev && out_ready) begin
                if (el) m_wc = m_wc + 16'd1;
                void'(m_q.pop_front());
            end
            if (in_valid && er) begin
                m_word = in_data;
                m_q.delete();
                for (int k = 0; k < 4; k++) if (in_mask[k]) m_q.push_back(k);
                if (in_mask == 4'd0) m_wc = m_wc + 16'd1;
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_mask = '0;
        tick(); tick();
        reset = 1'b0;
        sample();
        chk("rst_valid", 64'(v12), 64'd0);
        chk("rst_rdy",   64'(rdy12), 64'd1);
        chk("rst_data",  64'(d12), 64'd0);
        chk("rst_lane",  64'(ln12), 64'd0);
        chk("rst_last",  64'(l12), 64'd0);
        chk("rst_wc",    64'(wc12), 64'd0);

        // Four lanes, free-flowing output.
        tick();
        in_valid = 1'b1; in_data = 48'h003_002_001_000; in_mask = 4'b1111;
        sample();
        chk("t1_rdy", 64'(rdy12), 64'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("t1_valid", 64'(v12), 64'd1);
            chk("t1_lane",  64'(ln12), 64'(i));
            chk("t1_data",  64'(d12), 64'(i));
            chk("t1_last",  64'(l12), 64'(i == 3));
            tick();
        end
        sample();
        chk("t1_wc",    64'(wc12), 64'd1);
        chk("t1_idle",  64'(v12), 64'd0);

        // Narrow lanes drop the upper bits.
        tick();
        in_valid = 1'b1; in_data = 48'hFFF_0AB_123_0CD; in_mask = 4'b1010;
        sample();
        tick();
        in_valid = 1'b0;
        sample();
        chk("t2_lane_a",  64'(ln8), 64'd1);
        chk("t2_data8_a", 64'(d8),  64'h23);
        chk("t2_data12_a", 64'(d12), 64'h123);
        chk("t2_last_a",  64'(l8),  64'd0);
`ifdef DSP_UNPACK_OVF_EN
        chk("t2_ovf8_a",  64'(ovf8), 64'd1);
`endif
        tick();
        sample();
        chk("t2_lane_b",  64'(ln8), 64'd3);
        chk("t2_data8_b", 64'(d8),  64'hFF);
        chk("t2_data12_b", 64'(d12), 64'hFFF);
        chk("t2_last_b",  64'(l8),  64'd1);
`ifdef DSP_UNPACK_OVF_EN
        chk("t2_ovf8_b",  64'(ovf8), 64'd1);
        chk("t2_ovf12_b", 64'(ovf12), 64'd0);
`endif
        tick();
        sample();
        chk("t2_wc", 64'(wc8), 64'd2);

        // Back-to-back single-lane words.
        tick();
        in_valid = 1'b1; in_data = 48'h000_000_000_5A5; in_mask = 4'b0001;
        sample();
        tick();
        in_data = 48'h000_000_000_3C3;
        sample();
        chk("t3_data_a", 64'(d12), 64'h5A5);
        chk("t3_last_a", 64'(l12), 64'd1);
        chk("t3_rdy_a",  64'(rdy12), 64'd1);
        tick();
        in_valid = 1'b0;
        sample();
        chk("t3_valid_b", 64'(v12), 64'd1);
        chk("t3_data_b", 64'(d12), 64'h3C3);
        chk("t3_last_b", 64'(l12), 64'd1);
        chk("t3_wc_a",   64'(wc12), 64'd3);
        tick();
        sample();
        chk("t3_wc_b",   64'(wc12), 64'd4);

        // Backpressure holds the beat.
        tick();
        in_valid = 1'b1; in_data = 48'hABC_DEF_456_789; in_mask = 4'b0110; out_ready = 1'b0;
        sample();
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t4_hold_lane", 64'(ln12), 64'd1);
            chk("t4_hold_data", 64'(d12), 64'h456);
            chk("t4_hold_rdy",  64'(rdy12), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        sample();
        chk("t4_rel_lane", 64'(ln12), 64'd1);
        tick();
        sample();
        chk("t4_lane2", 64'(ln12), 64'd2);
        chk("t4_data2", 64'(d12), 64'hDEF);
        chk("t4_last2", 64'(l12), 64'd1);
        tick();
        sample();
        chk("t4_wc", 64'(wc12), 64'd5);

        // Empty mask retires with no beats.
        tick();
        in_valid = 1'b1; in_data = 48'h111_222_333_444; in_mask = 4'b0000;
        sample();
        tick();
        in_valid = 1'b0;
        sample();
        chk("t5_valid", 64'(v12), 64'd0);
        chk("t5_rdy",   64'(rdy12), 64'd1);
        chk("t5_wc",    64'(wc12), 64'd6);
        tick();
        sample();
        chk("t5_valid2", 64'(v12), 64'd0);

        // Reset in the middle of a word.
        tick();
        in_valid = 1'b1; in_data = 48'h444_333_222_111; in_mask = 4'b1111;
        sample();
        tick();
        in_valid = 1'b0;
        sample();
        chk("t6_data0", 64'(d12), 64'h111);
        tick();
        reset = 1'b1;
        sample();
        chk("t6_data1", 64'(d12), 64'h222);
        tick();
        reset = 1'b0;
        sample();
        chk("t6_valid", 64'(v12), 64'd0);
        chk("t6_rdy",   64'(rdy12), 64'd1);
        chk("t6_wc",    64'(wc12), 64'd0);
        tick();
        sample();
        chk("t6_valid2", 64'(v12), 64'd0);

        // Randomized traffic, checked by the model process every cycle.
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset     = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = {16'($urandom()), 32'($urandom())};
            in_mask   = 4'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsp_unpack_v4.md
Name: dsp_unpack_v4

Overview:
- Reader-side counterpart to the four-lane SIMD DSP adder.
- Accepts one 48-bit packed DSP result word (FOUR12 layout, lane k in bits [12k+11:12k]) per transfer.
- Emits the selected lanes serially, one lane per beat, on a valid/ready stream.
- Sits between a DSP48E2 P output (or its register) and narrow downstream consumers that take one lane at a time.

Parameters:
- width, 12, lane payload width emitted per beat; legal range 1..12; elaborate-time error outside that range.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  packed word offered.
- in_ready  out  1  block can accept a packed word this cycle.
- in_data  in  48  packed SIMD word; lane k = in_data[12k +: 12].
- in_mask  in  4  lane select; bit k=1 means lane k is emitted.
- out_valid  out  1  lane beat offered.
- out_ready  in  1  consumer accepts beat.
- out_data  out  width  lane payload = word[12k +: width].
- out_lane  out  2  index k of the lane being emitted.
- out_last  out  1  current beat is the final selected lane of its word.
- word_count  out  16  number of packed words fully retired, including mask=0 words; wraps 0xFFFF->0.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Ports are named clock and reset.
- State:
  - buf (48 b): latched word.
  - pend (4 b): lanes still to emit.
  - word_count.
- Reset values (on reset=1 at a clock edge):
  - pend=0, buf=0, word_count=0.
  - Outputs: out_valid=0, out_data=0, out_lane=0, out_last=0, in_ready=1.
  - Reset mid-word discards remaining lanes; no beat is produced for them.
- Lane selection:
  - k = index of lowest set bit of pend.
  - out_valid = (pend != 0).
  - out_lane = k.
  - out_data = buf[12k +: width]. Upper 12-width lane bits are discarded, which inverts the adder's zero-extension.
  - out_last = pend has exactly one bit set.
- Output gating: when out_valid=0, out_data, out_lane and out_last are driven 0.
- Beat handshake:
  - A beat transfers when out_valid && out_ready; bit k of pend is then cleared.
  - While out_valid=1 and out_ready=0, out_data, out_lane and out_last hold stable.
- Input handshake:
  - in_ready = (pend == 0) || (out_valid && out_ready && out_last). This is combinational from out_ready and allows back-to-back words with no bubble.
  - On in_valid && in_ready: buf <= in_data, pend <= in_mask.
  - in_data and in_mask are ignored when in_valid=0 or in_ready=0.
- Latency:
  - First lane of an accepted word is valid the cycle after acceptance.
  - A word with n selected lanes occupies n beats when out_ready stays high.
- mask=0 word:
  - Accepted, produces no beats.
  - word_count increments on the acceptance edge.
  - in_ready stays 1 the next cycle.
- word_count:
  - Increments on the edge where the out_last beat transfers, or where a mask=0 word is accepted.
  - Both events cannot occur on the same edge for the same word.
  - When the last beat of word N transfers and mask=0 word N+1 is accepted on the same edge, word_count increments by 2.
- Simultaneous last beat and new-word accept on the same edge: pend loads in_mask; the old word's last bit is not re-set.

Optional Feature:
- Macro: DSP_UNPACK_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 b) = OR of buf[12k+width +: 12-width] for the current lane, i.e. the lane's sum spilled past width bits.
  - Constant 0 when width=12.
  - Gated to 0 when out_valid=0; held stable with the other outputs under backpressure.
  - Resets to 0.
- Undefined: port and logic absent; the upper lane bits are silently truncated.

Test Plan:
1. Reset, then word 0x003_002_001_000 with mask=4'b1111 and out_ready=1 → beats (lane,data) = (0,0x000), (1,0x001), (2,0x002), (3,0x003) on 4 consecutive cycles; out_last only on lane 3; word_count=1.
2. width=8, word 0xFFF_0AB_123_0CD, mask=4'b1010 → beats (1,0x23) and (3,0xFF), last on lane 3. With DSP_UNPACK_OVF_EN: out_ovf = 1 on both beats.
3. Back-to-back: two words with mask=4'b0001, in_valid held high, out_ready=1 → in_ready stays 1; one beat per cycle, each with out_last=1; word_count=2 after 2 beats.
4. Backpressure: mask=4'b0110, out_ready=0 for 3 cycles → lane 1 beat held stable and in_ready=0 throughout; after release, beats lane 1 then lane 2.
5. mask=4'b0000 with in_valid for 1 cycle → no out_valid; word_count increments by 1; in_ready=1 on the next cycle.
6. Reset asserted after first beat of a 4-lane word → next cycle out_valid=0, in_ready=1, word_count=0; no further beats from that word.
